// File: rtl/niosii_irq_ctrl_pkg.sv
// Shared definitions for the Nios II interrupt aggregator.
// Contents:
//   - Avalon-MM register word addresses
//   - ACTIVE register field positions and CONTROL bit positions
//   - active_t: result of the fixed-priority search
//   - prio_enc(): lowest set index wins
package niosII_irq_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MODE    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_SWSET   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd6;

    localparam int VALID_BIT       = 15;
    localparam int ID_W            = 4;
    localparam int CONTROL_GIE_BIT = 0;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } active_t;

    // Scan from the top down so the lowest pending index is the one left standing.
    function automatic active_t prio_enc(input logic [DATA_W-1:0] v);
        active_t a;
        a.valid = 1'b0;
        a.id    = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                a.valid = 1'b1;
                a.id    = ID_W'(i);
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/niosii_irq_ctrl_if.sv
// Avalon-MM slave bus of the interrupt aggregator.
// Signals:
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write
//   writedata  write data (16 bits)
//   readdata   registered read data (16 bits), driven by the slave
interface niosii_irq_ctrl_if;
    import niosII_irq_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/niosii_irq_ctrl_sync_edge.sv
// Per-source input conditioning: SYNC_STAGES-deep synchronizer followed by a
// previous-sample flop used for rising-edge detection.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   d_i           raw interrupt line
//   sync_o        synchronized level
//   rise_o        synchronized rising edge (sync = 1, previous sample = 0)
module niosII_irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic prev_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_o = d_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q[0] <= d_i;
                    for (int j = 1; j < SYNC_STAGES; j++) begin
                        chain_q[j] <= chain_q[j-1];
                    end
                end
            end

            assign sync_o = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    // Tracked regardless of mode, so switching level->edge never fakes an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_o;
        end
    end

    assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/niosii_irq_ctrl.sv
// Nios II interrupt aggregator: up to 16 sources latched (edge or level) into
// PENDING, masked per source (ENABLE) and globally (CONTROL.GIE), reduced to
// one registered irq plus a fixed-priority ACTIVE id for the dispatcher.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq_in        source interrupt lines, bit 0 = system timer
//   irq           registered interrupt request to the CPU
module niosii_irq_ctrl
    import niosII_irq_pkg::*;
#(
    parameter int N_SRC       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    niosii_irq_ctrl_if.slave       bus,
    input  logic [N_SRC-1:0]       irq_in,
    output logic                   irq
);

    localparam logic [DATA_W-1:0] SRC_MASK = DATA_W'((32'd1 << N_SRC) - 32'd1);

    logic [DATA_W-1:0] sync_w, rise_w;
    logic [DATA_W-1:0] pending_q, pending_d;
    logic [DATA_W-1:0] enable_q, enable_d;
    logic [DATA_W-1:0] mode_q, mode_d;
    logic              gie_q, gie_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q, irq_d;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_src
            if (gi < N_SRC) begin : g_on
                niosII_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .d_i     (irq_in[gi]),
                    .sync_o  (sync_w[gi]),
                    .rise_o  (rise_w[gi])
                );
            end else begin : g_off
                assign sync_w[gi] = 1'b0;
                assign rise_w[gi] = 1'b0;
            end
        end
    endgenerate

    logic    wr_en, wr_pend, wr_swset, wr_ack;
    active_t active;
    logic [DATA_W-1:0] swset_v, w1c_v, ack_v, edge_next, active_word;

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign wr_pend  = wr_en && (bus.address == ADDR_PENDING);
    assign wr_swset = wr_en && (bus.address == ADDR_SWSET);
    assign wr_ack   = wr_en && (bus.address == ADDR_ACTIVE);

    assign active = prio_enc(pending_q & enable_q);

    // ACK acts on the ACTIVE value of this cycle, before any pending update.
    assign swset_v = wr_swset ? bus.writedata : '0;
    assign w1c_v   = wr_pend  ? bus.writedata : '0;
    assign ack_v   = (wr_ack && active.valid) ? (DATA_W'(1) << active.id) : '0;

    // Set terms are OR-ed after the clear so a simultaneous event is never lost.
    assign edge_next = rise_w | swset_v | (pending_q & ~(w1c_v | ack_v));

    always_comb begin
        active_word                = '0;
        active_word[VALID_BIT]     = active.valid;
        active_word[ID_W-1:0]      = active.id;
    end

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        gie_d    = gie_q;
        if (wr_en && bus.address == ADDR_ENABLE)  enable_d = bus.writedata & SRC_MASK;
        if (wr_en && bus.address == ADDR_MODE)    mode_d   = bus.writedata & SRC_MASK;
        if (wr_en && bus.address == ADDR_CONTROL) gie_d    = bus.writedata[CONTROL_GIE_BIT];

        // Level bits mirror the synchronized line; edge bits hold their latch.
        pending_d = ((mode_q & edge_next) | (~mode_q & sync_w)) & SRC_MASK;
        irq_d     = gie_q & (|(pending_q & enable_q));

        case (bus.address)
            ADDR_PENDING: readdata_d = pending_q;
            ADDR_ENABLE:  readdata_d = enable_q;
            ADDR_MODE:    readdata_d = mode_q;
            ADDR_ACTIVE:  readdata_d = active_word;
            ADDR_RAW:     readdata_d = sync_w;
            ADDR_CONTROL: readdata_d = DATA_W'(gie_q) << CONTROL_GIE_BIT;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            gie_q      <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            gie_q      <= gie_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_niosii_irq_ctrl.sv
// Directed bench for niosii_irq_ctrl. Stimulus pushes expected readdata / irq
// values into queues; a single monitor process pops and compares them.
module tb_niosii_irq_ctrl;
    import niosII_irq_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] rd_exp;
        logic        irq_exp;
    } imm_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] irq_in;
    logic        irq;

    niosii_irq_ctrl_if bus();

    niosii_irq_ctrl #(.N_SRC(16), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_in  (irq_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    exp_t rd_q[$];
    exp_t irq_q[$];
    imm_t imm_q[$];

    bit rd_req = 1'b0, irq_req = 1'b0, imm_req = 1'b0, fin_req = 1'b0;
    bit mon_rd = 1'b0, mon_irq = 1'b0;
    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        mon_rd  <= rd_req;
        mon_irq <= irq_req;
    end

    // Monitor: clocked compares on the falling edge, plus asynchronous snapshot
    // and end-of-run drain checks.
    always @(negedge clk or posedge imm_req or posedge fin_req) begin
        if (imm_req) begin
            while (imm_q.size() > 0) begin
                imm_t m;
                m = imm_q.pop_front();
                check({m.name, "_readdata"}, bus.readdata, m.rd_exp);
                check({m.name, "_irq"}, 16'(irq), 16'(m.irq_exp));
            end
        end else if (fin_req) begin
            check("rd_queue_drained", 16'(rd_q.size()), 16'd0);
            check("irq_queue_drained", 16'(irq_q.size()), 16'd0);
        end else begin
            if (mon_rd) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", bus.readdata, 16'hxxxx);
                end else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    check(e.name, bus.readdata, e.exp);
                end
            end
            if (mon_irq) begin
                if (irq_q.size() == 0) begin
                    check("irq_unexpected", 16'(irq), 16'hxxxx);
                end else begin
                    exp_t e;
                    e = irq_q.pop_front();
                    check(e.name, 16'(irq), e.exp);
                end
            end
        end
    end

    // Every bus task occupies exactly one clock: drive after an edge, return 1 ns
    // after the next edge.
    task automatic end_cycle();
        @(posedge clk);
        #1;
        rd_req  = 1'b0;
        irq_req = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic idle();
        end_cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        end_cycle();
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        rd_q.push_back('{name, exp});
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        rd_req         = 1'b1;
        end_cycle();
    endtask

    // Checks irq as it stands after the edge that ends the next bus task.
    task automatic expect_irq(input logic e, input string name);
        irq_q.push_back('{name, 16'(e)});
        irq_req = 1'b1;
    endtask

    task automatic snap(input logic [15:0] rd_exp, input logic irq_exp, input string name);
        imm_q.push_back('{name, rd_exp, irq_exp});
        imm_req = 1'b1;
        #1;
        imm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        irq_in         = '0;
        reset_n        = 1'b1;
        #1 reset_n = 1'b0;
        #1 snap(16'h0000, 1'b0, "reset_init");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        expect_irq(1'b0, "irq_after_reset");
        rd(ADDR_PENDING, 16'h0000, "pending_after_reset");
        rd(ADDR_CONTROL, 16'h0000, "control_after_reset");

        // Timer path, level mode.
        wr(ADDR_ENABLE, 16'h0001);
        wr(ADDR_CONTROL, 16'h0001);
        irq_in[0] = 1'b1;
        idle();
        idle();
        expect_irq(1'b0, "timer_irq_not_early");
        idle();
        expect_irq(1'b1, "timer_irq_k3");
        idle();
        rd(ADDR_ACTIVE, 16'h8000, "timer_active");
        rd(ADDR_RAW, 16'h0001, "timer_raw");
        irq_in[0] = 1'b0;
        idle();
        idle();
        expect_irq(1'b1, "timer_irq_hold");
        idle();
        expect_irq(1'b0, "timer_irq_drop");
        idle();

        // Edge capture, ACK and W1C.
        wr(ADDR_MODE, 16'h0006);
        wr(ADDR_ENABLE, 16'h0006);
        irq_in[2:1] = 2'b11;
        idle();
        irq_in[2:1] = 2'b00;
        idle();
        idle();
        idle();
        rd(ADDR_PENDING, 16'h0006, "edge_pending");
        rd(ADDR_ACTIVE, 16'h8001, "edge_active1");
        wr(ADDR_ACTIVE, 16'h0000);
        rd(ADDR_PENDING, 16'h0004, "ack_pending");
        expect_irq(1'b1, "ack_irq_still");
        rd(ADDR_ACTIVE, 16'h8002, "ack_active2");
        wr(ADDR_PENDING, 16'h0004);
        expect_irq(1'b0, "w1c_irq_low");
        rd(ADDR_PENDING, 16'h0000, "w1c_pending");

        // Rising edge and W1C on the same clock: the set survives.
        wr(ADDR_MODE, 16'h000E);
        wr(ADDR_ENABLE, 16'h000E);
        irq_in[3] = 1'b1;
        idle();
        idle();
        wr(ADDR_PENDING, 16'h0008);
        rd(ADDR_PENDING, 16'h0008, "set_wins");
        wr(ADDR_PENDING, 16'h0008);
        rd(ADDR_PENDING, 16'h0000, "w1c_after_collision");
        irq_in[3] = 1'b0;

        // Masking.
        wr(ADDR_ENABLE, 16'h0000);
        wr(ADDR_MODE, 16'h0010);
        wr(ADDR_SWSET, 16'h0010);
        expect_irq(1'b0, "mask_irq_low");
        rd(ADDR_PENDING, 16'h0010, "mask_pending");
        rd(ADDR_ACTIVE, 16'h0000, "mask_active_none");
        expect_irq(1'b0, "enable_irq_not_yet");
        wr(ADDR_ENABLE, 16'h0010);
        expect_irq(1'b1, "enable_irq_high");
        rd(ADDR_ACTIVE, 16'h8004, "enable_active4");
        wr(ADDR_CONTROL, 16'h0000);
        expect_irq(1'b0, "gie_off_irq_low");
        idle();

        // SWSET ignored on level bits; unmapped address.
        wr(ADDR_MODE, 16'h0020);
        wr(ADDR_SWSET, 16'h0060);
        rd(ADDR_PENDING, 16'h0020, "swset_pending");
        rd(3'd7, 16'h0000, "addr7_zero");
        rd(ADDR_MODE, 16'h0020, "mode_readback");

        // Asynchronous reset while irq is high.
        wr(ADDR_ENABLE, 16'h0020);
        wr(ADDR_CONTROL, 16'h0001);
        expect_irq(1'b1, "pre_reset_irq");
        rd(ADDR_PENDING, 16'h0020, "pre_reset_pending");
        idle();
        #2;
        snap(16'h0020, 1'b1, "pre_reset_snapshot");
        reset_n = 1'b0;
        irq_in  = '0;
        #1 snap(16'h0000, 1'b0, "async_reset");
        idle();
        idle();
        reset_n = 1'b1;
        expect_irq(1'b0, "post_reset_irq");
        rd(ADDR_PENDING, 16'h0000, "post_reset_pending");
        rd(ADDR_ENABLE, 16'h0000, "post_reset_enable");
        rd(ADDR_MODE, 16'h0000, "post_reset_mode");
        rd(ADDR_CONTROL, 16'h0000, "post_reset_control");
        idle();
        idle();

        fin_req = 1'b1;
        #1 fin_req = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
